tube_scan_controller: RTL and testbench
=======================================

Name: tube_scan_controller

Overview:
- Parametrised successor to the board's seven-segment tube driver. Drives DIGITS multiplexed hex digits with a programmable scan rate and an anti-ghosting blank interval.
- Adds per-digit enable, decimal-point, leading-zero blanking and blink masks, all loaded through a CPU register interface.
- Sits between the CPU's MMIO decode and the board tube pins. Everything runs on the FPGA clock domain.

Parameters:
DIGITS, 8, number of tube digits; legal range 1..8.
SCAN_DIV, 40000, clocks per digit slot; must be >= 2.
BLANK_CYCLES, 400, clocks at the start of each slot with all anodes off; must be < SCAN_DIV.
BLINK_FRAMES, 64, full scan frames per blink half-period; must be >= 1.

Ports:
iFpgaClock  in  1  system clock
iCpuResetN  in  1  asynchronous, active-low reset
iWriteEnable  in  1  register write strobe, one cycle per write
iAddress  in  2  register select
iWriteData  in  16  write data
oDigitalTubeNotEnable  out  DIGITS  anode selects, active low
oDigitalTubeShape  out  8  segments, active low; [7]=dp, [6:0]=g..a
oFrameDone  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0

Behaviour:
- Registers, written on the rising edge when iWriteEnable=1:
  - addr 0: nibbles of digits 3..0 (digit 0 = [3:0]).
  - addr 1: nibbles of digits 7..4. Nibbles at or above DIGITS are dropped.
  - addr 2: [7:0] enable mask, [15:8] dp mask.
  - addr 3: [0] leading-zero blank, [1] blink enable, [15:8] blink mask.
  - Mask bits at or above DIGITS are ignored.
- Reset (async on iCpuResetN=0):
  - Data=0, enable mask=all ones, dp mask=0, mode=0.
  - Prescaler=0, digit index=0, frame counter=0, blink phase=0.
  - oDigitalTubeNotEnable=all ones, oDigitalTubeShape=8'hFF, oFrameDone=0.
  - Reset mid-slot aborts the scan immediately. After release, scanning restarts at digit 0 with prescaler 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the digit index advances and wraps DIGITS-1 -> 0.
  - On that wrap, oFrameDone is asserted for the following cycle, and the frame counter increments.
  - When the frame counter reaches BLINK_FRAMES-1 it clears and the blink phase toggles.
- Outputs are registered, computed each cycle from the current digit index, the prescaler and the register contents.
  - A write at edge E is visible on the outputs at edge E+1.
  - A write on the same edge as a slot advance is not lost. The new slot shows the new value one cycle later.
- Anode i is driven low only when all of the following hold:
  - i == digit index;
  - prescaler >= BLANK_CYCLES;
  - enable bit i = 1;
  - digit i is not LZ-blanked;
  - digit i is not blink-blanked.
  - Otherwise all anodes are high.
- LZ-blanking: digit i (i>0) is blanked when mode[0]=1 and nibbles DIGITS-1..i are all zero. Digit 0 is never LZ-blanked.
- Blink-blanking: digit i is blanked when mode[1]=1, blink mask bit i = 1 and blink phase = 1.
- Segment encoding, active-high g..a, output inverted:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Shape[7] = ~dp mask[digit index].
  - When no anode is enabled, shape = 8'hFF.
- DIGITS=1: index stays 0 and oFrameDone pulses every SCAN_DIV cycles.
- iAddress values not matching a register are ignored (all four decode).

Test Plan (bench params DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2):
- Reset held, then released with no writes:
  - anodes all high until the first slot's blank cycle ends;
  - then digit 0 shows "0": anodes 8'hFE, shape 8'hC0;
  - full 8-digit rotation every 32 cycles;
  - oFrameDone pulse once per 32 cycles.
- Write addr0=16'h3210, addr1=16'hFEDC:
  - shape while digit 2 is active is 8'hA4;
  - shape while digit 7 is active is 8'h8E;
  - anode pattern for digit 7 is 8'h7F.
- Write addr1=0, addr0=16'h0050, addr3=16'h0001:
  - digits 7..2 stay dark, with anodes all high during their slots;
  - digit 1 shows 8'h92, digit 0 shows 8'hC0.
- Write addr2=16'h0405:
  - digits 1 and 3..7 stay dark;
  - digit 2 shows its nibble with shape[7]=0.
- Write addr3=16'h0102:
  - digit 0 dark in frames 2-3 and 6-7, visible in frames 0-1 and 4-5;
  - other digits unaffected.
- Pulse iCpuResetN low for 1 cycle while digit 5 is active:
  - outputs go to all-high / 8'hFF asynchronously;
  - registers clear;
  - scan resumes at digit 0 showing "0".

Source files
------------

// File: rtl/tube_scan_controller_if.sv
// rtl/tube_scan_controller_if.sv - CPU register write port and tube pin bundle
interface tube_scan_controller_if #(
   parameter int DIGITS = 8
);
   logic              iWriteEnable;
   logic [1:0]        iAddress;
   logic [15:0]       iWriteData;
   logic [DIGITS-1:0] oDigitalTubeNotEnable;
   logic [7:0]        oDigitalTubeShape;
   logic              oFrameDone;

   // CPU/MMIO side: issues register writes, observes the tube pins
   modport master (
      output iWriteEnable, iAddress, iWriteData,
      input  oDigitalTubeNotEnable, oDigitalTubeShape, oFrameDone
   );

   // Controller side
   modport slave (
      input  iWriteEnable, iAddress, iWriteData,
      output oDigitalTubeNotEnable, oDigitalTubeShape, oFrameDone
   );
endinterface

// File: rtl/tube_scan_controller.sv
// rtl/tube_scan_controller.sv - multiplexed hex tube scanner with blanking, LZ suppression and blink
module tube_scan_controller #(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 40000,
   parameter int BLANK_CYCLES = 400,
   parameter int BLINK_FRAMES = 64
) (
   input logic                   iFpgaClock,
   input logic                   iCpuResetN,
   tube_scan_controller_if.slave bus
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   // Scan timing state
   logic [PW-1:0] presc;
   logic [IW-1:0] digit_idx;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic          slot_end;
   logic          frame_end;

   // CPU-visible register contents
   logic [DIGITS-1:0][3:0] nib;
   logic [DIGITS-1:0]      en_mask;
   logic [DIGITS-1:0]      dp_mask;
   logic [DIGITS-1:0]      blink_mask;
   logic                   lz_mode;
   logic                   blink_mode;

   // Per-cycle output decode
   logic [DIGITS-1:0] lz_blank;
   logic              zero_run;
   logic              blink_hide;
   logic              lit;
   logic [DIGITS-1:0] next_anode;
   logic [7:0]        next_shape;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         4'hA:    return 7'h77;
         4'hB:    return 7'h7C;
         4'hC:    return 7'h39;
         4'hD:    return 7'h5E;
         4'hE:    return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   assign slot_end  = (presc == PRESC_LAST);
   assign frame_end = slot_end && (digit_idx == DIGIT_LAST);

   // Prescaler, digit rotation, frame count and blink phase
   always_ff @(posedge iFpgaClock or negedge iCpuResetN) begin
      if (!iCpuResetN) begin
         presc       <= '0;
         digit_idx   <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         presc <= slot_end ? '0 : presc + 1'b1;
         if (slot_end)
            digit_idx <= frame_end ? '0 : digit_idx + 1'b1;
         if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Register file writes; nibbles and mask bits beyond DIGITS are simply not stored
   always_ff @(posedge iFpgaClock or negedge iCpuResetN) begin
      if (!iCpuResetN) begin
         nib        <= '0;
         en_mask    <= '1;
         dp_mask    <= '0;
         blink_mask <= '0;
         lz_mode    <= 1'b0;
         blink_mode <= 1'b0;
      end else if (bus.iWriteEnable) begin
         case (bus.iAddress)
            2'd0, 2'd1: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if ((i < 4) == (bus.iAddress == 2'd0))
                     nib[i] <= bus.iWriteData[(i % 4) * 4 +: 4];
               end
            end
            2'd2: begin
               en_mask <= bus.iWriteData[DIGITS-1:0];
               dp_mask <= bus.iWriteData[8 +: DIGITS];
            end
            default: begin
               lz_mode    <= bus.iWriteData[0];
               blink_mode <= bus.iWriteData[1];
               blink_mask <= bus.iWriteData[8 +: DIGITS];
            end
         endcase
      end
   end

   // Leading-zero suppression: walk down from the top digit while nibbles stay zero
   always_comb begin
      lz_blank = '0;
      zero_run = lz_mode;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (nib[i] == 4'h0);
         if (i != 0)
            lz_blank[i] = zero_run;
      end
   end

   // Anode and segment pattern for the current slot, dark during the anti-ghost interval
   always_comb begin
      blink_hide = blink_mode && blink_mask[digit_idx] && blink_phase;
      lit        = (presc >= BLANK_END) && en_mask[digit_idx] &&
                   !lz_blank[digit_idx] && !blink_hide;
      next_anode = '1;
      next_shape = 8'hFF;
      if (lit) begin
         next_anode = ~(DIGITS'(1) << digit_idx);
         next_shape = {~dp_mask[digit_idx], ~seg_decode(nib[digit_idx])};
      end
   end

   // Registered tube pins and frame-wrap pulse
   always_ff @(posedge iFpgaClock or negedge iCpuResetN) begin
      if (!iCpuResetN) begin
         bus.oDigitalTubeNotEnable <= '1;
         bus.oDigitalTubeShape     <= 8'hFF;
         bus.oFrameDone            <= 1'b0;
      end else begin
         bus.oDigitalTubeNotEnable <= next_anode;
         bus.oDigitalTubeShape     <= next_shape;
         bus.oFrameDone            <= frame_end;
      end
   end
endmodule

// File: tb/tb_tube_scan_controller.sv
// tb/tb_tube_scan_controller.sv - self-checking bench for tube_scan_controller
module tb_tube_scan_controller;
   localparam int DIGITS       = 8;
   localparam int SCAN_DIV     = 4;
   localparam int BLANK_CYCLES = 1;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tube_scan_controller_if #(.DIGITS(DIGITS)) bus ();

   tube_scan_controller #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
      .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .iFpgaClock(clk),
      .iCpuResetN(rst_n),
      .bus(bus.slave)
   );

   // Reference model state
   logic [31:0] m_data;
   logic [7:0]  m_en, m_dp, m_bm;
   logic        m_lz, m_bl;
   int          cnt;
   logic [7:0]  seg_tbl [16];

   int tests = 0;
   int fails = 0;

   // Observation bookkeeping for directed checks
   int         fd_count;
   logic [7:0] shape_seen [8];
   logic       lit_seen [8];
   int         blink_dark_lit;
   int         blink_light_lit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data = '0; m_en = 8'hFF; m_dp = '0; m_bm = '0; m_lz = 1'b0; m_bl = 1'b0;
      cnt = 0;
   endtask

   task automatic model_write(input logic [1:0] a, input logic [15:0] d);
      case (a)
         2'd0: m_data[15:0]  = d;
         2'd1: m_data[31:16] = d;
         2'd2: begin m_en = d[7:0]; m_dp = d[15:8]; end
         default: begin m_lz = d[0]; m_bl = d[1]; m_bm = d[15:8]; end
      endcase
   endtask

   function automatic bit phase_of(input int c);
      return ((c / FRAME_LEN) / BLINK_FRAMES) % 2 == 1;
   endfunction

   // Expected pins produced by timing position c with the model registers
   task automatic model_out(input int c, output logic [7:0] an, output logic [7:0] sh);
      int p, d;
      bit lit;
      logic [3:0] n;
      p = c % SCAN_DIV;
      d = (c / SCAN_DIV) % DIGITS;
      n = m_data[4*d +: 4];
      lit = (p >= BLANK_CYCLES) && m_en[d]
            && !(m_lz && d > 0 && (m_data >> (4*d)) == 0)
            && !(m_bl && m_bm[d] && phase_of(c));
      an = 8'hFF;
      sh = 8'hFF;
      if (lit) begin
         an = ~(8'd1 << d);
         sh = {~m_dp[d], ~seg_tbl[n][6:0]};
      end
   endtask

   task automatic step(input bit wr, input logic [1:0] a, input logic [15:0] d);
      logic [7:0] ea, es;
      bus.iWriteEnable = wr;
      bus.iAddress     = a;
      bus.iWriteData   = d;
      @(posedge clk);
      #1;
      model_out(cnt, ea, es);
      check("anode", 32'(bus.oDigitalTubeNotEnable), 32'(ea));
      check("shape", 32'(bus.oDigitalTubeShape), 32'(es));
      check("frame_done", 32'(bus.oFrameDone), 32'((cnt % FRAME_LEN) == FRAME_LEN - 1));
      if (bus.oFrameDone) fd_count++;
      for (int k = 0; k < DIGITS; k++) begin
         if (bus.oDigitalTubeNotEnable == ~(8'd1 << k)) begin
            lit_seen[k]   = 1'b1;
            shape_seen[k] = bus.oDigitalTubeShape;
            if (k == 0) begin
               if (phase_of(cnt)) blink_dark_lit++;
               else               blink_light_lit++;
            end
         end
      end
      if (wr) model_write(a, d);
      cnt++;
      bus.iWriteEnable = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 2'd0, 16'h0);
   endtask

   task automatic clear_seen();
      for (int k = 0; k < 8; k++) begin
         lit_seen[k]   = 1'b0;
         shape_seen[k] = 8'hFF;
      end
      blink_dark_lit  = 0;
      blink_light_lit = 0;
   endtask

   function automatic int lit_count(input logic [7:0] sel);
      int s = 0;
      for (int k = 0; k < 8; k++) if (sel[k] && lit_seen[k]) s++;
      return s;
   endfunction

   initial begin
      seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      bus.iWriteEnable = 1'b0;
      bus.iAddress     = 2'd0;
      bus.iWriteData   = 16'h0;
      model_reset();
      clear_seen();
      fd_count = 0;

      // Reset held
      repeat (3) @(posedge clk);
      #1;
      check("reset_anode", 32'(bus.oDigitalTubeNotEnable), 32'hFF);
      check("reset_shape", 32'(bus.oDigitalTubeShape), 32'hFF);
      check("reset_fd", 32'(bus.oFrameDone), 32'h0);
      rst_n = 1'b1;

      // Idle scan after release
      step(1'b0, 2'd0, 16'h0);
      check("first_blank", 32'(bus.oDigitalTubeNotEnable), 32'hFF);
      step(1'b0, 2'd0, 16'h0);
      check("digit0_anode", 32'(bus.oDigitalTubeNotEnable), 32'hFE);
      check("digit0_shape", 32'(bus.oDigitalTubeShape), 32'hC0);
      idle(62);
      check("frame_pulses_64", fd_count, 2);

      // Hex digits
      step(1'b1, 2'd0, 16'h3210);
      step(1'b1, 2'd1, 16'hFEDC);
      clear_seen();
      idle(40);
      check("digit2_shape", 32'(shape_seen[2]), 32'hA4);
      check("digit7_shape", 32'(shape_seen[7]), 32'h8E);
      check("digit7_anode_seen", 32'(lit_seen[7]), 32'h1);

      // Leading-zero blanking
      step(1'b1, 2'd1, 16'h0000);
      step(1'b1, 2'd0, 16'h0050);
      step(1'b1, 2'd3, 16'h0001);
      idle(1);
      clear_seen();
      idle(32);
      check("lz_dark_7to2", lit_count(8'hFC), 0);
      check("lz_digit1", 32'(shape_seen[1]), 32'h92);
      check("lz_digit0", 32'(shape_seen[0]), 32'hC0);

      // Enable and decimal-point masks
      step(1'b1, 2'd0, 16'h0350);
      step(1'b1, 2'd2, 16'h0405);
      idle(1);
      clear_seen();
      idle(32);
      check("en_dark", lit_count(8'hFA), 0);
      check("en_digit2_dp", 32'(shape_seen[2]), 32'h30);
      check("en_digit0", 32'(shape_seen[0]), 32'hC0);

      // Blink on digit 0
      step(1'b1, 2'd3, 16'h0102);
      idle(1);
      clear_seen();
      idle(8 * FRAME_LEN);
      check("blink_dark_frames", blink_dark_lit, 0);
      check("blink_light_frames", 32'(blink_light_lit > 0), 32'h1);
      check("blink_other_digit", 32'(shape_seen[2]), 32'h30);

      // Mid-slot reset while digit 5 is showing
      step(1'b1, 2'd2, 16'h00FF);
      for (int k = 0; k < 64 && !(((cnt / SCAN_DIV) % DIGITS) == 5 && (cnt % SCAN_DIV) == 2); k++)
         idle(1);
      check("pre_reset_anode", 32'(bus.oDigitalTubeNotEnable), 32'hDF);
      rst_n = 1'b0;
      #1;
      check("async_anode", 32'(bus.oDigitalTubeNotEnable), 32'hFF);
      check("async_shape", 32'(bus.oDigitalTubeShape), 32'hFF);
      check("async_fd", 32'(bus.oFrameDone), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step(1'b0, 2'd0, 16'h0);
      check("post_reset_blank", 32'(bus.oDigitalTubeNotEnable), 32'hFF);
      step(1'b0, 2'd0, 16'h0);
      check("post_reset_anode", 32'(bus.oDigitalTubeNotEnable), 32'hFE);
      check("post_reset_shape", 32'(bus.oDigitalTubeShape), 32'hC0);
      idle(40);

      // Random register traffic, including writes coinciding with slot advances
      repeat (600) begin
         if ($urandom_range(0, 3) == 0)
            step(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
         else
            step(1'b0, 2'd0, 16'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
